if_fetch_unit: RTL and testbench

//  Instruction fetch unit: owns the PC, issues word reads to instruction ROM, buffers returned words
//  and presents {ins, ins_addr} to the if_id register that feeds the decoder. Handles jump redirect

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/if_fifo.sv | 62 ++++++
 rtl/if_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch slice.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INST_NOP           = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_STALL = 2'd2
    } fetch_state_e;

    // Sequential word address; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] next_word_addr(input logic [XLEN-1:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous instruction buffer: DEPTH entries of {addr, word}, push/pop/flush,
// occupancy count and register-backed head entry. DEPTH must be a power of two.
module if_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush && (count != CW'(DEPTH));
    assign do_pop  = pop && !flush && (count != '0);
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; flush empties the buffer in one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word reads to instruction ROM,
// buffers returned words and hands {ins, ins_addr} to the if_id register.
// Optional build macro IF_PERF_CNT_EN adds fetch/flush performance counters.
//
//   state   | meaning
//   S_BOOT  | first cycle after reset, no request
//   S_FETCH | requesting while credit is available
//   S_STALL | held by hazard control or out of credit
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_ADDR = RESET_ADDR_DEFAULT,
    parameter int              FIFO_DEPTH = 2,
    parameter int              MAX_OUTST  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_addr,
    input  logic            hold_en,
    output logic            rom_req,
    output logic [XLEN-1:0] rom_addr,
    input  logic            rom_gnt,
    input  logic            rom_rvalid,
    input  logic [XLEN-1:0] rom_rdata,
    output logic [XLEN-1:0] ins_o,
    output logic [XLEN-1:0] ins_addr_o,
    output logic            ins_valid_o,
    input  logic            ins_ready_i
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e      state;
    fetch_state_e      state_next;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   resp_pc;
    logic [OW-1:0]     outst;
    logic [OW-1:0]     outst_next;
    logic [OW-1:0]     discard;
    logic [CW-1:0]     fifo_count;
    logic [2*XLEN-1:0] fifo_head;
    logic              credit_ok;
    logic              issue;
    logic              resp;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_valid;

    // Every in-flight response must already own a buffer slot.
    assign credit_ok = (32'(outst) < MAX_OUTST) &&
                       ((32'(outst) + 32'(fifo_count)) < FIFO_DEPTH);

    assign rom_req    = (state == S_FETCH) && !jump_en && !hold_en && credit_ok;
    assign rom_addr   = pc;
    assign issue      = rom_req && rom_gnt;
    assign resp       = rom_rvalid && (outst != '0);
    assign fifo_push  = resp && !jump_en && (discard == '0);
    assign fifo_valid = (fifo_count != '0);
    assign fifo_pop   = fifo_valid && ins_ready_i && !jump_en;

    assign ins_valid_o = fifo_valid;
    assign ins_o       = fifo_valid ? fifo_head[XLEN-1:0]      : INST_NOP;
    assign ins_addr_o  = fifo_valid ? fifo_head[2*XLEN-1:XLEN] : '0;

    // Requests in flight after this edge.
    always_comb begin
        outst_next = outst;
        if (issue) begin
            outst_next = outst_next + OW'(1);
        end
        if (resp) begin
            outst_next = outst_next - OW'(1);
        end
    end

    // Next-state logic for the fetch sequencer.
    always_comb begin
        state_next = state;
        case (state)
            S_BOOT:  state_next = S_FETCH;
            S_FETCH: if (hold_en || !credit_ok) state_next = S_STALL;
            S_STALL: if (!hold_en && credit_ok) state_next = S_FETCH;
            default: state_next = S_BOOT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // PC, response tagging and in-flight bookkeeping; a jump overrides all of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_ADDR;
            resp_pc <= RESET_ADDR;
            outst   <= '0;
            discard <= '0;
        end else begin
            outst <= outst_next;
            if (jump_en) begin
                pc      <= jump_addr;
                resp_pc <= jump_addr;
                discard <= outst_next;
            end else begin
                if (issue) begin
                    pc <= next_word_addr(pc);
                end
                if (resp) begin
                    if (discard != '0) begin
                        discard <= discard - OW'(1);
                    end else begin
                        resp_pc <= next_word_addr(resp_pc);
                    end
                end
            end
        end
    end

    if_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({resp_pc, rom_rdata}),
        .pop       (fifo_pop),
        .flush     (jump_en),
        .count     (fifo_count),
        .head      (fifo_head)
    );

`ifdef IF_PERF_CNT_EN
    // Pops delivered to if_id, and words thrown away by redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (fifo_pop) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (jump_en) begin
                perf_flush_cnt <= perf_flush_cnt + 32'(fifo_count) + 32'(resp);
            end else if (resp && (discard != '0)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // Unrequested ROM data would corrupt the in-flight count.
    assert property (@(posedge clk) disable iff (rst) rom_rvalid |-> (outst != '0));
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit with an in-order ROM model and a
// stream-level reference: delivered words follow the PC sequence from reset
// or the latest jump target, each carrying the ROM word for its address.
module tb_if_fetch_unit;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        hold_en;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_gnt;
    logic        rom_rvalid;
    logic [31:0] rom_rdata;
    logic [31:0] ins_o;
    logic [31:0] ins_addr_o;
    logic        ins_valid_o;
    logic        ins_ready_i;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .hold_en     (hold_en),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_gnt     (rom_gnt),
        .rom_rvalid  (rom_rvalid),
        .rom_rdata   (rom_rdata),
        .ins_o       (ins_o),
        .ins_addr_o  (ins_addr_o),
        .ins_valid_o (ins_valid_o),
        .ins_ready_i (ins_ready_i)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    int          cyc;
    int          n_pops;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          gnt_pct = 100;
    logic [31:0] pend_a [$];
    int          pend_d [$];
    logic [31:0] exp_addr;
    logic [31:0] exp_req;

    logic        ev_req, ev_issue, ev_valid, ev_pop, ev_hold, ev_jump;
    logic [31:0] ev_req_addr, ev_req_exp, ev_ins, ev_iaddr, ev_pop_exp;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic do_reset();
        rst         = 1'b1;
        jump_en     = 1'b0;
        jump_addr   = 32'h0;
        hold_en     = 1'b0;
        rom_gnt     = 1'b0;
        rom_rvalid  = 1'b0;
        rom_rdata   = 32'h0;
        ins_ready_i = 1'b0;
        pend_a.delete();
        pend_d.delete();
        exp_addr = 32'h0;
        exp_req  = 32'h0;
        n_pops   = 0;
        cyc      = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        rom_gnt = (int'($urandom_range(99, 0)) < gnt_pct);
        rst     = 1'b0;
    endtask

    // One clock: sample outputs mid-cycle, advance ROM and reference model.
    task automatic tick();
        logic        issued;
        logic        s_jump;
        logic [31:0] s_jaddr;
        @(negedge clk);
        ev_req      = rom_req;
        ev_req_addr = rom_addr;
        ev_req_exp  = exp_req;
        ev_valid    = ins_valid_o;
        ev_ins      = ins_o;
        ev_iaddr    = ins_addr_o;
        ev_pop      = ins_valid_o && ins_ready_i && !jump_en;
        ev_pop_exp  = exp_addr;
        ev_hold     = hold_en;
        ev_jump     = jump_en;
        issued      = rom_req && rom_gnt;
        ev_issue    = issued;
        s_jump      = jump_en;
        s_jaddr     = jump_addr;
        @(posedge clk);
        #1;
        if (rom_rvalid) begin
            void'(pend_a.pop_front());
            void'(pend_d.pop_front());
        end
        if (issued) begin
            pend_a.push_back(ev_req_addr);
            pend_d.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
            exp_req = exp_req + 32'd4;
        end
        if (ev_pop) begin
            exp_addr = exp_addr + 32'd4;
            n_pops++;
        end
        if (s_jump) begin
            exp_req  = s_jaddr;
            exp_addr = s_jaddr;
        end
        cyc++;
        rom_gnt = (int'($urandom_range(99, 0)) < gnt_pct);
        if (pend_a.size() != 0 && pend_d[0] <= cyc) begin
            rom_rvalid = 1'b1;
            rom_rdata  = rom_fn(pend_a[0]);
        end else begin
            rom_rvalid = 1'b0;
            rom_rdata  = $urandom;
        end
    endtask

    task automatic test_reset();
        int first_valid;
        do_reset();
        n_chk++;
        if ({rom_req, ins_valid_o} !== 2'b00) $display("FAIL reset_req_valid: got %b required 00", {rom_req, ins_valid_o});
        else n_pass++;
        n_chk++;
        if (rom_addr !== 32'h0) $display("FAIL reset_rom_addr: got %h required 00000000", rom_addr);
        else n_pass++;
        n_chk++;
        if (ins_o !== INST_NOP) $display("FAIL reset_ins: got %h required %h", ins_o, INST_NOP);
        else n_pass++;
        n_chk++;
        if (ins_addr_o !== 32'h0) $display("FAIL reset_ins_addr: got %h required 00000000", ins_addr_o);
        else n_pass++;
        gnt_pct = 100; lat_lo = 1; lat_hi = 1; ins_ready_i = 1'b1;
        release_reset();
        first_valid = -1;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k == 0) begin
                n_chk++;
                if (ev_req !== 1'b0) $display("FAIL boot_no_req: got %b required 0", ev_req);
                else n_pass++;
            end
            if (ev_valid && first_valid < 0) first_valid = k;
            if (ev_pop) begin
                n_chk++;
                if (ev_iaddr !== ev_pop_exp || ev_ins !== rom_fn(ev_pop_exp))
                    $display("FAIL pop_order: got %h/%h required %h/%h", ev_iaddr, ev_ins, ev_pop_exp, rom_fn(ev_pop_exp));
                else n_pass++;
            end
            if (ev_req) begin
                n_chk++;
                if (ev_req_addr !== ev_req_exp) $display("FAIL req_addr: got %h required %h", ev_req_addr, ev_req_exp);
                else n_pass++;
            end
        end
        n_chk++;
        if (first_valid != 3) $display("FAIL first_valid_cycle: got %0d required 3", first_valid);
        else n_pass++;
        n_chk++;
        if (n_pops < 3) $display("FAIL initial_pops: got %0d required >=3", n_pops);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int grants;
        int pops_before;
        ins_ready_i = 1'b0;
        grants = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ev_issue) grants++;
            if (ev_pop) begin
                n_chk++;
                if (ev_iaddr !== ev_pop_exp || ev_ins !== rom_fn(ev_pop_exp))
                    $display("FAIL pop_order: got %h/%h required %h/%h", ev_iaddr, ev_ins, ev_pop_exp, rom_fn(ev_pop_exp));
                else n_pass++;
            end
            if (ev_req) begin
                n_chk++;
                if (ev_req_addr !== ev_req_exp) $display("FAIL req_addr: got %h required %h", ev_req_addr, ev_req_exp);
                else n_pass++;
            end
        end
        n_chk++;
        if (ev_req !== 1'b0 || ev_valid !== 1'b1)
            $display("FAIL bp_full: got req=%b valid=%b required req=0 valid=1", ev_req, ev_valid);
        else n_pass++;
        n_chk++;
        if (grants > 2) $display("FAIL bp_grants: got %0d required <=2", grants);
        else n_pass++;
        ins_ready_i = 1'b1;
        pops_before = n_pops;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (ev_pop) begin
                n_chk++;
                if (ev_iaddr !== ev_pop_exp || ev_ins !== rom_fn(ev_pop_exp))
                    $display("FAIL pop_order: got %h/%h required %h/%h", ev_iaddr, ev_ins, ev_pop_exp, rom_fn(ev_pop_exp));
                else n_pass++;
            end
            if (ev_req) begin
                n_chk++;
                if (ev_req_addr !== ev_req_exp) $display("FAIL req_addr: got %h required %h", ev_req_addr, ev_req_exp);
                else n_pass++;
            end
        end
        n_chk++;
        if (n_pops - pops_before < 3) $display("FAIL bp_drain: got %0d pops required >=3", n_pops - pops_before);
        else n_pass++;
    endtask

    task automatic test_jump();
        logic got;
        do_reset();
        gnt_pct = 100; lat_lo = 4; lat_hi = 4; ins_ready_i = 1'b1;
        release_reset();
        repeat (3) tick();
        n_chk++;
        if (pend_a.size() != 2) $display("FAIL inflight_before_jump: got %0d required 2", pend_a.size());
        else n_pass++;
        jump_en = 1'b1; jump_addr = 32'h0000_0100;
        tick();
        jump_en = 1'b0;
        n_chk++;
        if (ev_req !== 1'b0) $display("FAIL jump_no_req: got %b required 0", ev_req);
        else n_pass++;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            if (ev_pop) begin
                got = 1'b1;
                n_chk++;
                if (ev_iaddr !== 32'h100 || ev_ins !== rom_fn(32'h100))
                    $display("FAIL jump_first_word: got %h/%h required 00000100/%h", ev_iaddr, ev_ins, rom_fn(32'h100));
                else n_pass++;
            end
            if (ev_req) begin
                n_chk++;
                if (ev_req_addr !== ev_req_exp) $display("FAIL req_addr: got %h required %h", ev_req_addr, ev_req_exp);
                else n_pass++;
            end
        end
        n_chk++;
        if (!got) $display("FAIL jump_timeout: got no pop required one within 40 cycles");
        else n_pass++;
`ifdef IF_PERF_CNT_EN
        n_chk++;
        if (perf_flush_cnt !== 32'd2) $display("FAIL perf_flush: got %0d required 2", perf_flush_cnt);
        else n_pass++;
        n_chk++;
        if (perf_fetch_cnt !== 32'(n_pops)) $display("FAIL perf_fetch: got %0d required %0d", perf_fetch_cnt, n_pops);
        else n_pass++;
`endif
    endtask

    task automatic test_jump_collide();
        logic found;
        logic got;
        do_reset();
        gnt_pct = 100; lat_lo = 1; lat_hi = 1; ins_ready_i = 1'b1;
        release_reset();
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (rom_rvalid && ins_valid_o) found = 1'b1;
            else tick();
        end
        n_chk++;
        if (!found) $display("FAIL collide_setup: got no rvalid+valid cycle required one");
        else n_pass++;
        jump_en = 1'b1; jump_addr = 32'h0000_0200;
        tick();
        jump_en = 1'b0;
        n_chk++;
        if (ev_valid !== 1'b1) $display("FAIL collide_word_present: got %b required 1", ev_valid);
        else n_pass++;
        tick();
        n_chk++;
        if (ev_valid !== 1'b0 || ev_ins !== INST_NOP)
            $display("FAIL collide_flushed: got valid=%b ins=%h required 0/%h", ev_valid, ev_ins, INST_NOP);
        else n_pass++;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            tick();
            if (ev_pop) begin
                got = 1'b1;
                n_chk++;
                if (ev_iaddr !== 32'h200 || ev_ins !== rom_fn(32'h200))
                    $display("FAIL collide_first_word: got %h/%h required 00000200/%h", ev_iaddr, ev_ins, rom_fn(32'h200));
                else n_pass++;
            end
        end
        n_chk++;
        if (!got) $display("FAIL collide_timeout: got no pop required one within 30 cycles");
        else n_pass++;
    endtask

    task automatic test_hold();
        int   hold_pops;
        logic saw_req;
        do_reset();
        gnt_pct = 100; lat_lo = 2; lat_hi = 2; ins_ready_i = 1'b1;
        release_reset();
        for (int k = 0; k < 14; k++) begin
            if (k == 8) ins_ready_i = 1'b0;
            if (k == 11) begin hold_en = 1'b1; ins_ready_i = 1'b1; hold_pops = 0; end
            tick();
            if (k >= 11) begin
                n_chk++;
                if (ev_req !== 1'b0) $display("FAIL hold_no_req: got %b required 0", ev_req);
                else n_pass++;
                if (ev_pop) hold_pops++;
            end
            if (ev_pop) begin
                n_chk++;
                if (ev_iaddr !== ev_pop_exp || ev_ins !== rom_fn(ev_pop_exp))
                    $display("FAIL pop_order: got %h/%h required %h/%h", ev_iaddr, ev_ins, ev_pop_exp, rom_fn(ev_pop_exp));
                else n_pass++;
            end
        end
        hold_en = 1'b0;
        saw_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ev_pop) begin
                n_chk++;
                if (ev_iaddr !== ev_pop_exp || ev_ins !== rom_fn(ev_pop_exp))
                    $display("FAIL pop_order: got %h/%h required %h/%h", ev_iaddr, ev_ins, ev_pop_exp, rom_fn(ev_pop_exp));
                else n_pass++;
            end
            if (ev_req) begin
                saw_req = 1'b1;
                n_chk++;
                if (ev_req_addr !== ev_req_exp) $display("FAIL req_addr: got %h required %h", ev_req_addr, ev_req_exp);
                else n_pass++;
            end
        end
        n_chk++;
        if (hold_pops < 1) $display("FAIL hold_drain: got %0d pops required >=1", hold_pops);
        else n_pass++;
        n_chk++;
        if (!saw_req) $display("FAIL hold_resume: got no request required resume");
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int          seen;
        logic [31:0] third;
        do_reset();
        gnt_pct = 100; lat_lo = 3; lat_hi = 3; ins_ready_i = 1'b1;
        release_reset();
        repeat (4) tick();
        jump_en = 1'b1; jump_addr = 32'h0000_0300;
        tick();
        jump_addr = 32'hFFFF_FFF8;
        tick();
        jump_en = 1'b0;
        n_chk++;
        if (ev_req !== 1'b0) $display("FAIL b2b_no_req: got %b required 0", ev_req);
        else n_pass++;
        seen = 0;
        third = 32'hDEAD_BEEF;
        for (int k = 0; k < 60 && seen < 3; k++) begin
            tick();
            if (ev_pop) begin
                seen++;
                if (seen == 3) third = ev_iaddr;
                n_chk++;
                if (ev_iaddr !== ev_pop_exp || ev_ins !== rom_fn(ev_pop_exp))
                    $display("FAIL pop_order: got %h/%h required %h/%h", ev_iaddr, ev_ins, ev_pop_exp, rom_fn(ev_pop_exp));
                else n_pass++;
            end
        end
        n_chk++;
        if (third !== 32'h0000_0000) $display("FAIL b2b_wrap: got %h required 00000000", third);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        gnt_pct = 70; lat_lo = 1; lat_hi = 4; ins_ready_i = 1'b1;
        release_reset();
        for (int k = 0; k < 800; k++) begin
            ins_ready_i = ($urandom_range(3, 0) != 0);
            hold_en     = ($urandom_range(7, 0) == 0);
            jump_en     = ($urandom_range(19, 0) == 0);
            jump_addr   = $urandom & 32'hFFFF_FFFC;
            tick();
            if (ev_req && (ev_hold || ev_jump))
                $display("FAIL rand_req_blocked: got req=1 with hold=%b jump=%b required req=0", ev_hold, ev_jump);
            if (ev_hold || ev_jump) begin
                n_chk++;
                if (ev_req === 1'b0) n_pass++;
            end
            if (!ev_valid) begin
                n_chk++;
                if (ev_ins !== INST_NOP || ev_iaddr !== 32'h0)
                    $display("FAIL rand_idle_out: got %h/%h required %h/00000000", ev_ins, ev_iaddr, INST_NOP);
                else n_pass++;
            end
            if (ev_pop) begin
                n_chk++;
                if (ev_iaddr !== ev_pop_exp || ev_ins !== rom_fn(ev_pop_exp))
                    $display("FAIL pop_order: got %h/%h required %h/%h", ev_iaddr, ev_ins, ev_pop_exp, rom_fn(ev_pop_exp));
                else n_pass++;
            end
            if (ev_req) begin
                n_chk++;
                if (ev_req_addr !== ev_req_exp) $display("FAIL req_addr: got %h required %h", ev_req_addr, ev_req_exp);
                else n_pass++;
            end
        end
        jump_en = 1'b0;
        hold_en = 1'b0;
        n_chk++;
        if (n_pops < 50) $display("FAIL rand_progress: got %0d pops required >=50", n_pops);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_backpressure();
        test_jump();
        test_jump_collide();
        test_hold();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
